// File: rtl/serv_rf_pkg.sv
// Shared types and geometry helpers for the SERV register-file RAM path.
package serv_rf_pkg;

    typedef enum logic [1:0] {StInit, StIdle, StCore, StHost} arb_state_e;

    localparam int unsigned BurstLenDefault = 40;

    // 32 GPRs plus the CSR words, packed width bits per RAM word.
    function automatic int unsigned calc_aw(input int unsigned data_w, input int unsigned n_csr);
        return 5 + $clog2(32 + n_csr) - $clog2(data_w);
    endfunction

    function automatic int unsigned calc_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/serv_rf_ram_init.sv
// Post-reset clear sequencer: walks every RF RAM word once and then raises done.
module serv_rf_ram_init #(
    parameter int unsigned aw    = 8,
    parameter int unsigned depth = 256
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic [aw-1:0] o_addr,
    output logic          o_active,
    output logic          o_last,
    output logic          o_done
);

    localparam logic [aw-1:0] LastAddr = aw'(depth - 1);

    logic [aw-1:0] addr_q;
    logic          active_q;
    logic          done_q;

    // The idle cycle after reset keeps the RAM write enable low while reset is held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q   <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (!done_q) begin
            if (!active_q) begin
                active_q <= 1'b1;
            end else begin
                addr_q <= addr_q + aw'(1);
                if (o_last) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign o_addr   = addr_q;
    assign o_active = active_q;
    assign o_last   = active_q && (addr_q == LastAddr);
    assign o_done   = done_q;

endmodule

// File: rtl/serv_rf_ram_arbiter.sv
// RF RAM arbiter: clears the RAM after reset, forwards core RF bursts and slots
// single-cycle host word accesses into idle RAM cycles with bounded starvation.
module serv_rf_ram_arbiter
    import serv_rf_pkg::*;
#(
    parameter int unsigned width      = 8,
    parameter int unsigned csr_regs   = 4,
    parameter int unsigned aw         = calc_aw(width, csr_regs),
    parameter int unsigned depth      = calc_depth(aw),
    parameter int unsigned burst_len  = BurstLenDefault,
    parameter int unsigned starve_max = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_core_rreq,
    input  logic             i_core_wreq,
    output logic             o_core_ready,
    output logic             o_if_rreq,
    output logic             o_if_wreq,
    input  logic             i_if_ready,
    input  logic [aw-1:0]    i_if_waddr,
    input  logic [width-1:0] i_if_wdata,
    input  logic             i_if_wen,
    input  logic [aw-1:0]    i_if_raddr,
    input  logic             i_if_ren,
    output logic [width-1:0] o_if_rdata,
    input  logic             i_host_valid,
    input  logic             i_host_we,
    input  logic [aw-1:0]    i_host_addr,
    input  logic [width-1:0] i_host_wdata,
    output logic             o_host_ready,
    output logic             o_host_rvalid,
    output logic [width-1:0] o_host_rdata,
    output logic [aw-1:0]    o_ram_waddr,
    output logic [width-1:0] o_ram_wdata,
    output logic             o_ram_wen,
    output logic [aw-1:0]    o_ram_raddr,
    output logic             o_ram_ren,
    input  logic [width-1:0] i_ram_rdata,
    output logic             o_init_done
);

    localparam int unsigned     CntW      = $clog2(burst_len + 1);
    localparam int unsigned     StvW      = $clog2(starve_max + 1);
    localparam logic [CntW-1:0] BurstLen  = CntW'(burst_len);
    localparam logic [StvW-1:0] StarveMax = StvW'(starve_max);

    arb_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [StvW-1:0]  starve_q, starve_d;
    logic             rd_pend_q;
    logic [width-1:0] rdata_q;

    logic          init_active, init_last, init_done;
    logic [aw-1:0] init_addr;
    logic          core_req, core_win, host_win, arb_open;

    // Ownership is timed purely by burst_len, so the interface ready is not needed.
    logic if_ready_unused;
    assign if_ready_unused = i_if_ready;

    serv_rf_ram_init #(
        .aw    (aw),
        .depth (depth)
    ) u_init (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .o_addr   (init_addr),
        .o_active (init_active),
        .o_last   (init_last),
        .o_done   (init_done)
    );

    assign core_req = i_core_rreq | i_core_wreq;
    // The cycle carrying host read data arbitrates exactly like idle.
    assign arb_open = (state_q == StIdle) || (state_q == StHost);

    always_comb begin
        host_win = 1'b0;
        core_win = 1'b0;
        if (arb_open) begin
            host_win = i_host_valid && (!core_req || (starve_q == StarveMax));
            core_win = core_req && !host_win;
        end else if (state_q == StCore) begin
            core_win = core_req;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        starve_d = starve_q;
        if (state_q == StInit) begin
            if (init_last) state_d = StIdle;
        end else if (core_win) begin
            state_d = StCore;
            cnt_d   = BurstLen;
        end else if (host_win) begin
            state_d = StHost;
        end else if (state_q == StCore) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) state_d = StIdle;
        end else begin
            state_d = StIdle;
        end
        if (host_win) begin
            starve_d = '0;
        end else if (arb_open && core_win && i_host_valid) begin
            starve_d = starve_q + StvW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            starve_q  <= '0;
            rd_pend_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            rd_pend_q <= host_win && !i_host_we;
            if (rd_pend_q) rdata_q <= i_ram_rdata;
        end
    end

    always_comb begin
        o_ram_wen   = 1'b0;
        o_ram_ren   = 1'b0;
        o_ram_waddr = '0;
        o_ram_wdata = '0;
        o_ram_raddr = '0;
        if (init_active) begin
            o_ram_wen   = 1'b1;
            o_ram_waddr = init_addr;
        end else if (host_win) begin
            o_ram_waddr = i_host_addr;
            o_ram_wdata = i_host_wdata;
            o_ram_raddr = i_host_addr;
            o_ram_wen   = i_host_we;
            o_ram_ren   = !i_host_we;
        end else if (state_q == StCore) begin
            o_ram_waddr = i_if_waddr;
            o_ram_wdata = i_if_wdata;
            o_ram_raddr = i_if_raddr;
            o_ram_wen   = i_if_wen;
            o_ram_ren   = i_if_ren;
        end
    end

    assign o_core_ready  = core_win;
    assign o_if_rreq     = core_win & i_core_rreq;
    assign o_if_wreq     = core_win & i_core_wreq;
    assign o_host_ready  = host_win;
    assign o_host_rvalid = rd_pend_q;
    assign o_host_rdata  = rd_pend_q ? i_ram_rdata : rdata_q;
    assign o_if_rdata    = i_ram_rdata;
    assign o_init_done   = init_done;

endmodule

// File: tb/tb_serv_rf_ram_arbiter.sv
// Bench for serv_rf_ram_arbiter: init sweep, arbitration vectors, burst reload,
// starvation pattern, reset abort and randomized traffic against a reference model.
module tb_serv_rf_ram_arbiter;

    localparam int unsigned W     = 8;
    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 256;
    localparam int          BURST = 40;
    localparam int          SMAX  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          core_rreq, core_wreq, core_ready, if_rreq, if_wreq;
    logic          if_ready, if_wen, if_ren;
    logic [AW-1:0] if_waddr, if_raddr, host_addr, ram_waddr, ram_raddr;
    logic [W-1:0]  if_wdata, if_rdata, host_wdata, host_rdata, ram_wdata;
    logic          host_valid, host_we, host_ready, host_rvalid;
    logic          ram_wen, ram_ren, init_done;
    logic [W-1:0]  ram_rdata = '0;
    logic [W-1:0]  ram_mem [DEPTH];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int           own_left;
    int           starve;
    bit           rd_pend;
    logic [W-1:0] rd_expect;
    logic [W-1:0] mem_model [DEPTH];
    bit           obs_c, obs_h;

    typedef struct {
        bit         r, w, hv, we;
        logic [7:0] addr, wdata;
        bit         e_cr, e_ir, e_iw, e_hr, e_wen, e_ren;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    serv_rf_ram_arbiter dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_core_rreq   (core_rreq),
        .i_core_wreq   (core_wreq),
        .o_core_ready  (core_ready),
        .o_if_rreq     (if_rreq),
        .o_if_wreq     (if_wreq),
        .i_if_ready    (if_ready),
        .i_if_waddr    (if_waddr),
        .i_if_wdata    (if_wdata),
        .i_if_wen      (if_wen),
        .i_if_raddr    (if_raddr),
        .i_if_ren      (if_ren),
        .o_if_rdata    (if_rdata),
        .i_host_valid  (host_valid),
        .i_host_we     (host_we),
        .i_host_addr   (host_addr),
        .i_host_wdata  (host_wdata),
        .o_host_ready  (host_ready),
        .o_host_rvalid (host_rvalid),
        .o_host_rdata  (host_rdata),
        .o_ram_waddr   (ram_waddr),
        .o_ram_wdata   (ram_wdata),
        .o_ram_wen     (ram_wen),
        .o_ram_raddr   (ram_raddr),
        .o_ram_ren     (ram_ren),
        .i_ram_rdata   (ram_rdata),
        .o_init_done   (init_done)
    );

    always @(posedge clk) begin
        if (ram_wen) ram_mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= ram_mem[ram_raddr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        own_left = 0;
        starve   = 0;
        rd_pend  = 0;
        foreach (mem_model[i]) mem_model[i] = '0;
    endtask

    // Check one post-init cycle against the arbitration rules, then advance the model.
    task automatic model_cycle();
        bit creq, cwin, hwin;
        creq = core_rreq | core_wreq;
        if (own_left > 0) begin
            cwin = creq;
            hwin = 0;
        end else begin
            hwin = host_valid && (!creq || starve == SMAX);
            cwin = creq && !hwin;
        end
        obs_c = core_ready;
        obs_h = host_ready;
        chk("core_ready", 32'(core_ready), 32'(cwin));
        chk("if_rreq", 32'(if_rreq), 32'(cwin & core_rreq));
        chk("if_wreq", 32'(if_wreq), 32'(cwin & core_wreq));
        chk("host_ready", 32'(host_ready), 32'(hwin));
        chk("init_done", 32'(init_done), 1);
        chk("if_rdata", 32'(if_rdata), 32'(ram_rdata));
        chk("host_rvalid", 32'(host_rvalid), 32'(rd_pend));
        if (rd_pend) chk("host_rdata", 32'(host_rdata), 32'(rd_expect));
        if (hwin) begin
            chk("host_wen", 32'(ram_wen), 32'(host_we));
            chk("host_ren", 32'(ram_ren), 32'(!host_we));
            if (host_we) begin
                chk("host_waddr", 32'(ram_waddr), 32'(host_addr));
                chk("host_wdata", 32'(ram_wdata), 32'(host_wdata));
            end else begin
                chk("host_raddr", 32'(ram_raddr), 32'(host_addr));
            end
        end else if (own_left > 0) begin
            chk("core_wen", 32'(ram_wen), 32'(if_wen));
            chk("core_ren", 32'(ram_ren), 32'(if_ren));
            if (if_wen) begin
                chk("core_waddr", 32'(ram_waddr), 32'(if_waddr));
                chk("core_wdata", 32'(ram_wdata), 32'(if_wdata));
            end
            if (if_ren) chk("core_raddr", 32'(ram_raddr), 32'(if_raddr));
        end else begin
            chk("idle_wen", 32'(ram_wen), 0);
            chk("idle_ren", 32'(ram_ren), 0);
        end
        if (own_left > 0 && if_wen) mem_model[if_waddr] = if_wdata;
        rd_pend = hwin && !host_we;
        if (hwin) begin
            if (host_we) mem_model[host_addr] = host_wdata;
            else rd_expect = mem_model[host_addr];
            starve = 0;
        end else if (cwin && host_valid && own_left == 0) begin
            starve++;
        end
        if (cwin) own_left = BURST;
        else if (own_left > 0) own_left--;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && (own_left > 0 || rd_pend); i++) step();
        if (own_left > 0 || rd_pend) chk("wait_idle_timeout", 0, 1);
    endtask

    task automatic run_init(input bit core_hold);
        int exp_addr = 0;
        bit prev_last = 0;
        bit seen = 0;
        for (int c = 0; c < 600 && !seen; c++) begin
            @(negedge clk);
            if (init_done) begin
                seen = 1;
                chk("init_count", 32'(exp_addr), DEPTH);
                chk("init_done_timing", 32'(prev_last), 1);
                if (core_hold) begin
                    chk("core_after_init", 32'(core_ready), 1);
                    chk("rreq_after_init", 32'(if_rreq), 1);
                end
                model_cycle();
            end else begin
                chk("init_stall_core", 32'(core_ready), 0);
                chk("init_stall_host", 32'(host_ready), 0);
                prev_last = 0;
                if (ram_wen) begin
                    chk("init_waddr", 32'(ram_waddr), 32'(exp_addr));
                    chk("init_wdata", 32'(ram_wdata), 0);
                    prev_last = (exp_addr == DEPTH - 1);
                    exp_addr++;
                end
            end
            @(posedge clk);
            #1;
        end
        if (!seen) chk("init_timeout", 0, 1);
    endtask

    task automatic rand_phase(input int n);
        for (int c = 0; c < n; c++) begin
            if (!core_rreq && !core_wreq && $urandom_range(0, 29) == 0) begin
                core_rreq = 1'($urandom_range(0, 1));
                core_wreq = !core_rreq;
            end
            if (!host_valid && $urandom_range(0, 2) == 0) begin
                host_valid = 1'b1;
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = 8'($urandom_range(0, 15));
                host_wdata = 8'($urandom);
            end
            if_wen   = 1'($urandom_range(0, 1));
            if_ren   = 1'($urandom_range(0, 1));
            if_waddr = 8'($urandom_range(0, 15));
            if_raddr = 8'($urandom_range(0, 15));
            if_wdata = 8'($urandom);
            step();
            if (obs_c) begin
                core_rreq = 1'b0;
                core_wreq = 1'b0;
            end
            if (obs_h) host_valid = 1'b0;
        end
        core_rreq = 1'b0;
        core_wreq = 1'b0;
        host_valid = 1'b0;
        if_wen = 1'b0;
        if_ren = 1'b0;
        wait_idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_core_ready"}, 32'(core_ready), 0);
        chk({tag, "_if_rreq"}, 32'(if_rreq), 0);
        chk({tag, "_if_wreq"}, 32'(if_wreq), 0);
        chk({tag, "_host_ready"}, 32'(host_ready), 0);
        chk({tag, "_host_rvalid"}, 32'(host_rvalid), 0);
        chk({tag, "_host_rdata"}, 32'(host_rdata), 0);
        chk({tag, "_ram_wen"}, 32'(ram_wen), 0);
        chk({tag, "_ram_ren"}, 32'(ram_ren), 0);
        chk({tag, "_init_done"}, 32'(init_done), 0);
    endtask

    initial begin
        string seq;
        int n;
        core_rreq = 0; core_wreq = 0; if_ready = 0;
        if_wen = 0; if_ren = 0; if_waddr = '0; if_raddr = '0; if_wdata = '0;
        host_valid = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        model_reset();

        vecs[0] = '{1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 0};
        vecs[1] = '{0, 1, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 0, 0};
        vecs[2] = '{0, 0, 1, 1, 8'h12, 8'hA5, 0, 0, 0, 1, 1, 0};
        vecs[3] = '{0, 0, 1, 0, 8'h12, 8'h00, 0, 0, 0, 1, 0, 1};
        vecs[4] = '{1, 0, 1, 0, 8'h12, 8'h00, 1, 1, 0, 0, 0, 0};
        vecs[5] = '{0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0};

        #12;
        chk_all_zero("reset");

        // Core read held through the whole init sweep.
        core_rreq = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_init(1);
        core_rreq = 1'b0;
        wait_idle();

        foreach (vecs[i]) begin
            core_rreq  = vecs[i].r;
            core_wreq  = vecs[i].w;
            host_valid = vecs[i].hv;
            host_we    = vecs[i].we;
            host_addr  = vecs[i].addr;
            host_wdata = vecs[i].wdata;
            @(negedge clk);
            chk("vec_core_ready", 32'(core_ready), 32'(vecs[i].e_cr));
            chk("vec_if_rreq", 32'(if_rreq), 32'(vecs[i].e_ir));
            chk("vec_if_wreq", 32'(if_wreq), 32'(vecs[i].e_iw));
            chk("vec_host_ready", 32'(host_ready), 32'(vecs[i].e_hr));
            chk("vec_ram_wen", 32'(ram_wen), 32'(vecs[i].e_wen));
            chk("vec_ram_ren", 32'(ram_ren), 32'(vecs[i].e_ren));
            model_cycle();
            @(posedge clk);
            #1;
            core_rreq = 0; core_wreq = 0; host_valid = 0;
            if (i == 3) begin
                @(negedge clk);
                chk("rd_rvalid", 32'(host_rvalid), 1);
                chk("rd_data_a5", 32'(host_rdata), 32'h0000_00A5);
                model_cycle();
                @(posedge clk);
                #1;
            end
            wait_idle();
        end

        // Core write arriving at counter 5 reloads ownership to a full burst.
        core_rreq = 1'b1;
        step();
        core_rreq = 1'b0;
        for (int i = 0; i < 60 && own_left != 5; i++) step();
        core_wreq = 1'b1; host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h12;
        step();
        chk("reload_fwd", 32'(obs_c), 1);
        core_wreq = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            n++;
            if (obs_h) break;
        end
        chk("reload_len", 32'(n), 41);
        host_valid = 1'b0;
        wait_idle();

        // Core and host both always asking.
        seq = "";
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h03;
        for (int c = 0; c < 400 && seq.len() < 8; c++) begin
            core_rreq = (own_left == 0);
            step();
            if (obs_c) seq = {seq, "C"};
            if (obs_h) seq = {seq, "H"};
        end
        total++;
        if (seq != "CCCHCCCH") begin
            bad++;
            $display("FAIL starve_pattern: got %s want CCCHCCCH", seq);
        end
        core_rreq = 1'b0;
        host_valid = 1'b0;
        wait_idle();

        rand_phase(1500);

        // Reset asserted mid-burst, away from any clock edge.
        core_rreq = 1'b1; if_wen = 1'b1; if_ren = 1'b1;
        step();
        core_rreq = 1'b0;
        for (int i = 0; i < 60 && own_left != 20; i++) step();
        chk("pre_reset_wen", 32'(ram_wen), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        if_wen = 1'b0; if_ren = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run_init(0);
        rand_phase(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
